// File: rtl/axi_pkg.sv
// Shared AXI encodings and FSM state types for the AXI slave memory model.
// Provides burst/response codes, write/read state enums and a burst
// legality helper.
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;

  // A burst is serviceable only at full bus width with FIXED or INCR addressing.
  function automatic logic burst_legal(input logic [2:0] size,
                                       input logic [1:0] burst,
                                       input logic [2:0] full_size);
    logic burst_ok;
    case (burst)
      BURST_FIXED, BURST_INCR: burst_ok = 1'b1;
      BURST_WRAP:              burst_ok = 1'b0;
      default:                 burst_ok = 1'b0;
    endcase
    return burst_ok && (size == full_size);
  endfunction

endpackage

// File: rtl/axi_mem_ram.sv
// Byte-enabled simple dual-port RAM backing the AXI slave memory model.
// Ports: clk, rst (resets the read register only), we/wr_addr/wr_data/wr_strb
// write port, rd_en/rd_addr/rd_data synchronous read port.
// A read and a write to the same word in one cycle return the old contents.
module axi_mem_ram #(
  parameter int unsigned DATA_W = 512,
  parameter int unsigned AW     = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [DATA_W/8-1:0]   wr_strb,
  input  logic                  rd_en,
  input  logic [AW-1:0]         rd_addr,
  output logic [DATA_W-1:0]     rd_data
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned DEPTH = 1 << AW;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (wr_strb[i]) mem[wr_addr][i*8 +: 8] <= wr_data[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/axi_slave_mem.sv
// AXI4 slave memory model: accepts write/read bursts and answers with B/R
// responses from an internal byte-enabled RAM. One outstanding transaction
// per direction; write and read sides run independently.
// Ports: clk, rst (async, active high), AW/W/B write channels, AR/R read
// channels. lock/cache/prot are accepted and ignored.
module axi_slave_mem
  import axi_pkg::*;
#(
  parameter int unsigned DATA_W = 512,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned ID_W   = 4,
  parameter int unsigned MEM_AW = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ID_W-1:0]     s_axi_awid,
  input  logic [ADDR_W-1:0]   s_axi_awaddr,
  input  logic [7:0]          s_axi_awlen,
  input  logic [2:0]          s_axi_awsize,
  input  logic [1:0]          s_axi_awburst,
  input  logic                s_axi_awlock,
  input  logic [3:0]          s_axi_awcache,
  input  logic [2:0]          s_axi_awprot,
  input  logic                s_axi_awvalid,
  output logic                s_axi_awready,
  input  logic [DATA_W-1:0]   s_axi_wdata,
  input  logic [DATA_W/8-1:0] s_axi_wstrb,
  input  logic                s_axi_wlast,
  input  logic                s_axi_wvalid,
  output logic                s_axi_wready,
  output logic [ID_W-1:0]     s_axi_bid,
  output logic [1:0]          s_axi_bresp,
  output logic                s_axi_bvalid,
  input  logic                s_axi_bready,
  input  logic [ID_W-1:0]     s_axi_arid,
  input  logic [ADDR_W-1:0]   s_axi_araddr,
  input  logic [7:0]          s_axi_arlen,
  input  logic [2:0]          s_axi_arsize,
  input  logic [1:0]          s_axi_arburst,
  input  logic                s_axi_arlock,
  input  logic [3:0]          s_axi_arcache,
  input  logic [2:0]          s_axi_arprot,
  input  logic                s_axi_arvalid,
  output logic                s_axi_arready,
  output logic [ID_W-1:0]     s_axi_rid,
  output logic [DATA_W-1:0]   s_axi_rdata,
  output logic [1:0]          s_axi_rresp,
  output logic                s_axi_rlast,
  output logic                s_axi_rvalid,
  input  logic                s_axi_rready
);

  localparam int unsigned ADDR_LSB = $clog2(DATA_W / 8);

  logic unused_ok;
  assign unused_ok = ^{s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awaddr,
                       s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_araddr};

  // Holds address-ready low until the first clock edge after reset release.
  logic rst_done;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rst_done <= 1'b0;
    else     rst_done <= 1'b1;
  end

  // ---------------- write side ----------------
  w_state_t            w_state, w_state_nx;
  logic [ID_W-1:0]     w_id;
  logic [MEM_AW-1:0]   w_addr;
  logic [7:0]          w_len, w_cnt;
  logic                w_legal, w_incr, w_err;
  logic                aw_hs, w_hs, b_hs, w_final;

  assign s_axi_awready = rst_done && (w_state == W_IDLE);
  assign s_axi_wready  = (w_state == W_DATA);
  assign s_axi_bvalid  = (w_state == W_RESP);
  assign s_axi_bid     = w_id;
  assign s_axi_bresp   = w_err ? RESP_SLVERR : RESP_OKAY;

  assign aw_hs   = s_axi_awvalid && s_axi_awready;
  assign w_hs    = s_axi_wvalid && s_axi_wready;
  assign b_hs    = s_axi_bvalid && s_axi_bready;
  assign w_final = (w_cnt == w_len);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) w_state <= W_IDLE;
    else     w_state <= w_state_nx;
  end

  // The burst length comes from awlen; wlast is only cross-checked.
  always_comb begin
    w_state_nx = w_state;
    case (w_state)
      W_IDLE:  if (aw_hs)            w_state_nx = W_DATA;
      W_DATA:  if (w_hs && w_final)  w_state_nx = W_RESP;
      W_RESP:  if (b_hs)             w_state_nx = W_IDLE;
      default:                       w_state_nx = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_id    <= '0;
      w_addr  <= '0;
      w_len   <= '0;
      w_cnt   <= '0;
      w_legal <= 1'b0;
      w_incr  <= 1'b0;
      w_err   <= 1'b0;
    end else if (aw_hs) begin
      w_id    <= s_axi_awid;
      w_addr  <= s_axi_awaddr[ADDR_LSB +: MEM_AW];
      w_len   <= s_axi_awlen;
      w_cnt   <= '0;
      w_legal <= burst_legal(s_axi_awsize, s_axi_awburst, 3'(ADDR_LSB));
      w_incr  <= (s_axi_awburst == BURST_INCR);
      w_err   <= !burst_legal(s_axi_awsize, s_axi_awburst, 3'(ADDR_LSB));
    end else if (w_hs) begin
      w_cnt <= w_cnt + 8'd1;
      if (w_incr)                  w_addr <= w_addr + MEM_AW'(1);
      if (s_axi_wlast != w_final)  w_err  <= 1'b1;
    end
  end

  // ---------------- read side ----------------
  r_state_t            r_state, r_state_nx;
  logic [ID_W-1:0]     r_id;
  logic [MEM_AW-1:0]   r_addr;
  logic [7:0]          r_len, r_cnt;
  logic                r_legal, r_incr;
  logic                ar_hs, r_hs, r_final;

  assign s_axi_arready = rst_done && (r_state == R_IDLE);
  assign s_axi_rvalid  = (r_state == R_DATA);
  assign s_axi_rid     = r_id;
  assign s_axi_rlast   = s_axi_rvalid && r_final;
  assign s_axi_rresp   = (s_axi_rvalid && !r_legal) ? RESP_SLVERR : RESP_OKAY;

  assign ar_hs   = s_axi_arvalid && s_axi_arready;
  assign r_hs    = s_axi_rvalid && s_axi_rready;
  assign r_final = (r_cnt == r_len);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= R_IDLE;
    else     r_state <= r_state_nx;
  end

  always_comb begin
    r_state_nx = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_state_nx = R_FETCH;
      R_FETCH:            r_state_nx = R_DATA;
      R_DATA:  if (r_hs)  r_state_nx = r_final ? R_IDLE : R_FETCH;
      default:            r_state_nx = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_id    <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_legal <= 1'b0;
      r_incr  <= 1'b0;
    end else if (ar_hs) begin
      r_id    <= s_axi_arid;
      r_addr  <= s_axi_araddr[ADDR_LSB +: MEM_AW];
      r_len   <= s_axi_arlen;
      r_cnt   <= '0;
      r_legal <= burst_legal(s_axi_arsize, s_axi_arburst, 3'(ADDR_LSB));
      r_incr  <= (s_axi_arburst == BURST_INCR);
    end else if (r_hs && !r_final) begin
      r_cnt <= r_cnt + 8'd1;
      if (r_incr) r_addr <= r_addr + MEM_AW'(1);
    end
  end

  // rdata is the RAM read register: it only changes in R_FETCH, so it stays
  // stable for the whole R_DATA stall.
  axi_mem_ram #(
    .DATA_W (DATA_W),
    .AW     (MEM_AW)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we      (w_hs && w_legal),
    .wr_addr (w_addr),
    .wr_data (s_axi_wdata),
    .wr_strb (s_axi_wstrb),
    .rd_en   (r_state == R_FETCH),
    .rd_addr (r_addr),
    .rd_data (s_axi_rdata)
  );

endmodule

// File: tb/tb_axi_slave_mem.sv
// Self-checking bench for axi_slave_mem: randomized bursts checked against a
// word/byte-level memory model indexed by AXI address.
module tb_axi_slave_mem;

  localparam int DW = 512;
  localparam int SW = DW / 8;
  localparam int DEPTH = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]    s_axi_awid = '0;
  logic [31:0]   s_axi_awaddr = '0;
  logic [7:0]    s_axi_awlen = '0;
  logic [2:0]    s_axi_awsize = '0;
  logic [1:0]    s_axi_awburst = '0;
  logic          s_axi_awlock = 1'b0;
  logic [3:0]    s_axi_awcache = '0;
  logic [2:0]    s_axi_awprot = '0;
  logic          s_axi_awvalid = 1'b0;
  logic          s_axi_awready;
  logic [DW-1:0] s_axi_wdata = '0;
  logic [SW-1:0] s_axi_wstrb = '0;
  logic          s_axi_wlast = 1'b0;
  logic          s_axi_wvalid = 1'b0;
  logic          s_axi_wready;
  logic [3:0]    s_axi_bid;
  logic [1:0]    s_axi_bresp;
  logic          s_axi_bvalid;
  logic          s_axi_bready = 1'b0;
  logic [3:0]    s_axi_arid = '0;
  logic [31:0]   s_axi_araddr = '0;
  logic [7:0]    s_axi_arlen = '0;
  logic [2:0]    s_axi_arsize = '0;
  logic [1:0]    s_axi_arburst = '0;
  logic          s_axi_arlock = 1'b0;
  logic [3:0]    s_axi_arcache = '0;
  logic [2:0]    s_axi_arprot = '0;
  logic          s_axi_arvalid = 1'b0;
  logic          s_axi_arready;
  logic [3:0]    s_axi_rid;
  logic [DW-1:0] s_axi_rdata;
  logic [1:0]    s_axi_rresp;
  logic          s_axi_rlast;
  logic          s_axi_rvalid;
  logic          s_axi_rready = 1'b0;

  axi_slave_mem #(
    .DATA_W (DW),
    .ADDR_W (32),
    .ID_W   (4),
    .MEM_AW (10)
  ) dut (
    .clk (clk), .rst (rst),
    .s_axi_awid (s_axi_awid), .s_axi_awaddr (s_axi_awaddr), .s_axi_awlen (s_axi_awlen),
    .s_axi_awsize (s_axi_awsize), .s_axi_awburst (s_axi_awburst), .s_axi_awlock (s_axi_awlock),
    .s_axi_awcache (s_axi_awcache), .s_axi_awprot (s_axi_awprot),
    .s_axi_awvalid (s_axi_awvalid), .s_axi_awready (s_axi_awready),
    .s_axi_wdata (s_axi_wdata), .s_axi_wstrb (s_axi_wstrb), .s_axi_wlast (s_axi_wlast),
    .s_axi_wvalid (s_axi_wvalid), .s_axi_wready (s_axi_wready),
    .s_axi_bid (s_axi_bid), .s_axi_bresp (s_axi_bresp), .s_axi_bvalid (s_axi_bvalid),
    .s_axi_bready (s_axi_bready),
    .s_axi_arid (s_axi_arid), .s_axi_araddr (s_axi_araddr), .s_axi_arlen (s_axi_arlen),
    .s_axi_arsize (s_axi_arsize), .s_axi_arburst (s_axi_arburst), .s_axi_arlock (s_axi_arlock),
    .s_axi_arcache (s_axi_arcache), .s_axi_arprot (s_axi_arprot),
    .s_axi_arvalid (s_axi_arvalid), .s_axi_arready (s_axi_arready),
    .s_axi_rid (s_axi_rid), .s_axi_rdata (s_axi_rdata), .s_axi_rresp (s_axi_rresp),
    .s_axi_rlast (s_axi_rlast), .s_axi_rvalid (s_axi_rvalid), .s_axi_rready (s_axi_rready)
  );

  int checks = 0;
  int failures = 0;

  // Beat stimulus for the next write burst.
  logic [DW-1:0] wd [256];
  logic [SW-1:0] ws [256];

  // Reference memory: contents plus a per-byte "has been written" mask.
  logic [DW-1:0] model_mem   [DEPTH];
  logic [SW-1:0] model_known [DEPTH];

  function automatic int word_of(input logic [31:0] a);
    return int'((a >> 6) % DEPTH);
  endfunction

  function automatic bit legal(input logic [2:0] size, input logic [1:0] burst);
    return (size == 3'd6) && (burst == 2'b00 || burst == 2'b01);
  endfunction

  function automatic logic [DW-1:0] byte_mask(input logic [SW-1:0] k);
    logic [DW-1:0] m;
    for (int i = 0; i < SW; i++) m[i*8 +: 8] = {8{k[i]}};
    return m;
  endfunction

  task automatic model_write(input logic [31:0] addr, input int len,
                             input logic [2:0] size, input logic [1:0] burst);
    int w;
    if (!legal(size, burst)) return;
    w = word_of(addr);
    for (int b = 0; b <= len; b++) begin
      for (int i = 0; i < SW; i++) begin
        if (ws[b][i]) begin
          model_mem[w][i*8 +: 8] = wd[b][i*8 +: 8];
          model_known[w][i] = 1'b1;
        end
      end
      if (burst == 2'b01) w = (w + 1) % DEPTH;
    end
  endtask

  task automatic fill_random(input int len, input bit sparse);
    for (int b = 0; b <= len; b++) begin
      for (int j = 0; j < 16; j++) wd[b][j*32 +: 32] = $urandom;
      ws[b] = '1;
      if (sparse && $urandom_range(0, 2) == 0) ws[b] = {$urandom, $urandom};
    end
  endtask

  // Entered and left at a negedge.
  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                          input logic [2:0] size, input logic [1:0] burst,
                          input int wlast_at, input int stall, input string tag);
    int n;
    logic [1:0] exp_resp;
    exp_resp = (!legal(size, burst) || wlast_at != len) ? 2'b10 : 2'b00;
    s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = 8'(len);
    s_axi_awsize = size; s_axi_awburst = burst; s_axi_awvalid = 1'b1;
    n = 0;
    while (!s_axi_awready && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (s_axi_awready !== 1'b1) begin
      failures++;
      $display("FAIL %s aw_timeout: awready=%b required 1", tag, s_axi_awready);
      s_axi_awvalid = 1'b0;
      return;
    end
    @(posedge clk); #1 s_axi_awvalid = 1'b0;
    @(negedge clk);
    for (int b = 0; b <= len; b++) begin
      s_axi_wdata = wd[b]; s_axi_wstrb = ws[b];
      s_axi_wlast = (b == wlast_at); s_axi_wvalid = 1'b1;
      checks++;
      if (s_axi_wready !== 1'b1) begin
        failures++;
        $display("FAIL %s wready beat %0d: got %b required 1", tag, b, s_axi_wready);
        s_axi_wvalid = 1'b0;
        return;
      end
      @(posedge clk); #1 s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (s_axi_bvalid !== 1'b1 || s_axi_wready !== 1'b0) begin
      failures++;
      $display("FAIL %s b_latency: bvalid=%b wready=%b required 1/0", tag, s_axi_bvalid, s_axi_wready);
      n = 0;
      while (!s_axi_bvalid && n < 50) begin @(negedge clk); n++; end
    end
    for (int i = 0; i < stall; i++) begin
      checks++;
      if (s_axi_bvalid !== 1'b1 || s_axi_bid !== id || s_axi_bresp !== exp_resp) begin
        failures++;
        $display("FAIL %s b_stall cycle %0d: bvalid=%b bid=%h bresp=%b required 1/%h/%b",
                 tag, i, s_axi_bvalid, s_axi_bid, s_axi_bresp, id, exp_resp);
      end
      @(negedge clk);
    end
    checks++;
    if (s_axi_bid !== id) begin
      failures++;
      $display("FAIL %s bid: got %h required %h", tag, s_axi_bid, id);
    end
    checks++;
    if (s_axi_bresp !== exp_resp) begin
      failures++;
      $display("FAIL %s bresp: got %b required %b", tag, s_axi_bresp, exp_resp);
    end
    s_axi_bready = 1'b1;
    @(posedge clk); #1 s_axi_bready = 1'b0;
    @(negedge clk);
    checks++;
    if (s_axi_bvalid !== 1'b0 || s_axi_awready !== 1'b1) begin
      failures++;
      $display("FAIL %s b_done: bvalid=%b awready=%b required 0/1", tag, s_axi_bvalid, s_axi_awready);
    end
    model_write(addr, len, size, burst);
  endtask

  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                         input logic [2:0] size, input logic [1:0] burst,
                         input bit toggle, input string tag);
    int n, w;
    bit exp_err;
    logic [DW-1:0] snap_d;
    logic snap_l;
    logic [1:0] snap_r;
    exp_err = !legal(size, burst);
    w = word_of(addr);
    s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = 8'(len);
    s_axi_arsize = size; s_axi_arburst = burst; s_axi_arvalid = 1'b1;
    n = 0;
    while (!s_axi_arready && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (s_axi_arready !== 1'b1) begin
      failures++;
      $display("FAIL %s ar_timeout: arready=%b required 1", tag, s_axi_arready);
      s_axi_arvalid = 1'b0;
      return;
    end
    @(posedge clk); #1 s_axi_arvalid = 1'b0;
    @(negedge clk);
    checks++;
    if (s_axi_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL %s r_latency_early: rvalid=%b required 0", tag, s_axi_rvalid);
    end
    @(negedge clk);
    checks++;
    if (s_axi_rvalid !== 1'b1) begin
      failures++;
      $display("FAIL %s r_latency: rvalid=%b required 1", tag, s_axi_rvalid);
    end
    for (int b = 0; b <= len; b++) begin
      n = 0;
      while (!s_axi_rvalid && n < 20) begin @(negedge clk); n++; end
      checks++;
      if (s_axi_rvalid !== 1'b1) begin
        failures++;
        $display("FAIL %s r_timeout beat %0d: rvalid=%b required 1", tag, b, s_axi_rvalid);
        return;
      end
      checks++;
      if (s_axi_rid !== id) begin
        failures++;
        $display("FAIL %s rid beat %0d: got %h required %h", tag, b, s_axi_rid, id);
      end
      checks++;
      if (s_axi_rlast !== (b == len)) begin
        failures++;
        $display("FAIL %s rlast beat %0d: got %b required %b", tag, b, s_axi_rlast, (b == len));
      end
      checks++;
      if (s_axi_rresp !== (exp_err ? 2'b10 : 2'b00)) begin
        failures++;
        $display("FAIL %s rresp beat %0d: got %b required %b", tag, b, s_axi_rresp,
                 (exp_err ? 2'b10 : 2'b00));
      end
      if (!exp_err) begin
        checks++;
        if (((s_axi_rdata ^ model_mem[w]) & byte_mask(model_known[w])) !== '0) begin
          failures++;
          $display("FAIL %s rdata beat %0d: got %h required %h", tag, b, s_axi_rdata, model_mem[w]);
        end
      end
      if (toggle && (b % 2 == 0)) begin
        snap_d = s_axi_rdata; snap_l = s_axi_rlast; snap_r = s_axi_rresp;
        @(negedge clk);
        checks++;
        if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== snap_d || s_axi_rlast !== snap_l ||
            s_axi_rresp !== snap_r) begin
          failures++;
          $display("FAIL %s r_stall beat %0d: rvalid=%b rlast=%b rresp=%b required 1/%b/%b",
                   tag, b, s_axi_rvalid, s_axi_rlast, s_axi_rresp, snap_l, snap_r);
        end
      end
      s_axi_rready = 1'b1;
      @(posedge clk); #1 s_axi_rready = 1'b0;
      @(negedge clk);
      if (burst == 2'b01) w = (w + 1) % DEPTH;
    end
    checks++;
    if (s_axi_rvalid !== 1'b0 || s_axi_arready !== 1'b1) begin
      failures++;
      $display("FAIL %s r_done: rvalid=%b arready=%b required 0/1", tag, s_axi_rvalid, s_axi_arready);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bresp, s_axi_bid, s_axi_arready,
         s_axi_rvalid, s_axi_rlast, s_axi_rresp, s_axi_rid} !== '0 || s_axi_rdata !== '0) begin
      failures++;
      $display("FAIL reset_outputs: aw=%b w=%b b=%b ar=%b r=%b required all 0",
               s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (s_axi_awready !== 1'b0 || s_axi_arready !== 1'b0) begin
      failures++;
      $display("FAIL reset_release_early: awready=%b arready=%b required 0/0", s_axi_awready, s_axi_arready);
    end
    @(posedge clk); #1;
    checks++;
    if (s_axi_awready !== 1'b1 || s_axi_arready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release: awready=%b arready=%b required 1/1", s_axi_awready, s_axi_arready);
    end
    @(negedge clk);
  endtask

  task automatic test_incr;
    logic [3:0] id;
    for (int k = 0; k < 4; k++) begin
      wd[k] = DW'(k * 'h11);
      ws[k] = '1;
    end
    id = 4'($urandom);
    do_write(id, 32'h100, 3, 3'd6, 2'b01, 3, 0, "incr_wr");
    do_read(~id, 32'h100, 3, 3'd6, 2'b01, 1'b0, "incr_rd");
  endtask

  task automatic test_strobe;
    logic [DW-1:0] exp;
    wd[0] = '1; ws[0] = '1;
    do_write(4'h3, 32'h1000, 0, 3'd6, 2'b01, 0, 0, "strb_full");
    wd[0] = '0; ws[0] = 64'h1;
    do_write(4'h4, 32'h1000, 0, 3'd6, 2'b01, 0, 0, "strb_byte0");
    do_read(4'h5, 32'h1000, 0, 3'd6, 2'b01, 1'b0, "strb_rd");
    exp = '1;
    exp[7:0] = 8'h00;
    checks++;
    if (model_mem[word_of(32'h1000)] !== exp) begin
      failures++;
      $display("FAIL strb_model: got %h required %h", model_mem[word_of(32'h1000)], exp);
    end
  endtask

  task automatic test_illegal;
    fill_random(1, 1'b0);
    do_write(4'h6, 32'h100, 1, 3'd3, 2'b01, 1, 0, "illegal_size_wr");
    do_read(4'h7, 32'h100, 1, 3'd6, 2'b01, 1'b0, "illegal_size_rd");
    do_read(4'h8, 32'h100, 3, 3'd6, 2'b10, 1'b0, "wrap_rd");
  endtask

  task automatic test_wlast;
    fill_random(3, 1'b0);
    do_write(4'h9, 32'h2000, 3, 3'd6, 2'b01, 1, 0, "wlast_early_wr");
    do_read(4'h9, 32'h2000, 3, 3'd6, 2'b01, 1'b0, "wlast_early_rd");
  endtask

  task automatic test_stall;
    fill_random(2, 1'b0);
    do_write(4'hA, 32'h3000, 2, 3'd6, 2'b01, 2, 5, "stall_wr");
    do_read(4'hB, 32'h3000, 2, 3'd6, 2'b01, 1'b1, "stall_rd");
  endtask

  task automatic test_fixed;
    fill_random(3, 1'b0);
    for (int b = 0; b < 4; b++) ws[b] = {16{4'(1 << b)}};
    do_write(4'hC, 32'h5000, 3, 3'd6, 2'b00, 3, 0, "fixed_wr");
    do_read(4'hD, 32'h5000, 3, 3'd6, 2'b00, 1'b0, "fixed_rd");
  endtask

  task automatic test_random;
    logic [31:0] addr;
    int len;
    logic [1:0] burst;
    logic [3:0] id;
    for (int t = 0; t < 16; t++) begin
      addr  = $urandom;
      len   = $urandom_range(0, 15);
      burst = 2'($urandom_range(0, 1));
      id    = 4'($urandom);
      fill_random(len, 1'b1);
      do_write(id, addr, len, 3'd6, burst, len, $urandom_range(0, 2), "rand_wr");
      do_read(id, addr, len, 3'd6, burst, 1'($urandom_range(0, 1)), "rand_rd");
    end
  endtask

  task automatic test_long;
    logic [31:0] addr;
    addr = 32'hABC0_0000 | (32'd1000 << 6);
    fill_random(255, 1'b0);
    do_write(4'hE, addr, 255, 3'd6, 2'b01, 255, 0, "long_wr");
    do_read(4'hE, addr, 255, 3'd6, 2'b01, 1'b0, "long_rd");
  endtask

  task automatic test_rst_mid;
    int n;
    for (int b = 0; b < 8; b++) begin
      wd[b] = {16{32'hA5A5_0000 + 32'(b)}};
      ws[b] = '1;
    end
    do_write(4'h1, 32'h8000, 7, 3'd6, 2'b01, 7, 0, "rm_pre");
    fill_random(7, 1'b0);
    s_axi_awid = 4'h2; s_axi_awaddr = 32'h8000; s_axi_awlen = 8'd7;
    s_axi_awsize = 3'd6; s_axi_awburst = 2'b01; s_axi_awvalid = 1'b1;
    n = 0;
    while (!s_axi_awready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1 s_axi_awvalid = 1'b0;
    @(negedge clk);
    for (int b = 0; b < 2; b++) begin
      s_axi_wdata = wd[b]; s_axi_wstrb = '1; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b1;
      checks++;
      if (s_axi_wready !== 1'b1) begin
        failures++;
        $display("FAIL rm_wready beat %0d: got %b required 1", b, s_axi_wready);
      end
      @(posedge clk); #1;
      @(negedge clk);
    end
    s_axi_wdata = wd[2];
    rst = 1'b1;
    #1;
    checks++;
    if (s_axi_bvalid !== 1'b0 || s_axi_wready !== 1'b0 || s_axi_awready !== 1'b0) begin
      failures++;
      $display("FAIL rm_in_reset: bvalid=%b wready=%b awready=%b required 0/0/0",
               s_axi_bvalid, s_axi_wready, s_axi_awready);
    end
    s_axi_wvalid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (s_axi_awready !== 1'b0) begin
      failures++;
      $display("FAIL rm_release_early: awready=%b required 0", s_axi_awready);
    end
    @(posedge clk); #1;
    checks++;
    if (s_axi_awready !== 1'b1 || s_axi_bvalid !== 1'b0) begin
      failures++;
      $display("FAIL rm_release: awready=%b bvalid=%b required 1/0", s_axi_awready, s_axi_bvalid);
    end
    @(negedge clk);
    model_write(32'h8000, 1, 3'd6, 2'b01);
    do_read(4'h3, 32'h8000, 7, 3'd6, 2'b01, 1'b0, "rm_rd");
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      model_mem[i] = '0;
      model_known[i] = '0;
    end
    test_reset();
    test_incr();
    test_strobe();
    test_illegal();
    test_wlast();
    test_stall();
    test_fixed();
    test_random();
    test_long();
    test_rst_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
